// File: rtl/nios2os_oci_pkg.sv
// Shared definitions for the OCI debug-memory controller: jdo field positions and FSM/op encodings.
// Pure declarations; no latency or backpressure of its own.
package nios2os_oci_pkg;

    localparam int ADDR_LSB  = 26;
    localparam int RD_FLAG   = 35;
    localparam int WDATA_LSB = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_JTAG_RD
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } pend_op_t;

endpackage

// File: rtl/nios2os_ocimem_jtag_cmd.sv
// JTAG strobe decode into a one-deep pending op, plus MonAReg and the sticky overrun flag; 1-cycle decode.
// No backpressure to JTAG: strobes arriving while an op is pending are dropped and flagged.
module nios2os_ocimem_jtag_cmd
    import nios2os_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              op_done,
    output pend_op_t          pend_op,
    output logic [DATA_W-1:0] pend_data,
    output logic [ADDR_W-1:0] mon_areg,
    output logic              overrun
);

    pend_op_t req_op;
    logic     pending;
    logic     any_strobe;
    logic     unused_jdo;

    // Only some jdo bits carry fields; fold the rest so they are visibly consumed.
    assign unused_jdo = ^jdo;

    assign pending    = (pend_op != OP_NONE);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        req_op = OP_NONE;
        if (take_action_ocimem_a) begin
            req_op = jdo[RD_FLAG] ? OP_READ : OP_NONE;
        end else if (take_action_ocimem_b) begin
            req_op = OP_WRITE;
        end else if (take_no_action_ocimem_a) begin
            req_op = OP_READ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_op   <= OP_NONE;
            pend_data <= '0;
            mon_areg  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (op_done) begin
                pend_op <= OP_NONE;
            end else if (!pending && req_op != OP_NONE) begin
                pend_op   <= req_op;
                pend_data <= jdo[WDATA_LSB +: DATA_W];
            end

            if (pending && any_strobe) begin
                overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
                overrun <= 1'b0;
            end

            // An address load always lands, even when its read is dropped.
            if (take_action_ocimem_a) begin
                mon_areg <= jdo[ADDR_LSB +: ADDR_W];
            end else if (op_done) begin
                mon_areg <= mon_areg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2os_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG (priority) and the CPU debug slave; writes 1 cycle, reads 2.
// CPU is stalled via av_waitrequest while JTAG owns the RAM or its read is in flight.
module nios2os_ocimem_arbiter
    import nios2os_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    arb_state_t        state;
    arb_state_t        next_state;
    pend_op_t          pend_op;
    logic [DATA_W-1:0] pend_data;
    logic              jtag_done;
    logic              mond_load;
    logic              wren_c;
    logic [DATA_W-1:0] readdata_c;

    nios2os_ocimem_jtag_cmd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_cmd (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .op_done                 (jtag_done),
        .pend_op                 (pend_op),
        .pend_data               (pend_data),
        .mon_areg                (MonAReg),
        .overrun                 (jtag_overrun)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        ram_addr       = MonAReg;
        wren_c         = 1'b0;
        ram_byteen     = 4'hF;
        ram_wdata      = pend_data;
        readdata_c     = '0;
        av_waitrequest = av_read | av_write;
        jtag_done      = 1'b0;
        mond_load      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pend_op == OP_READ) begin
                    next_state = ST_JTAG_RD;
                end else if (pend_op == OP_WRITE) begin
                    wren_c    = 1'b1;
                    jtag_done = 1'b1;
                end else if (av_write) begin
                    // Write wins a simultaneous read; the held read is served next cycle.
                    wren_c         = 1'b1;
                    ram_addr       = av_address;
                    ram_byteen     = av_byteenable;
                    ram_wdata      = av_writedata;
                    av_waitrequest = 1'b0;
                end else if (av_read) begin
                    ram_addr   = av_address;
                    next_state = ST_CPU_RD;
                end
            end
            ST_CPU_RD: begin
                ram_addr       = av_address;
                readdata_c     = ram_rdata;
                av_waitrequest = 1'b0;
                next_state     = ST_IDLE;
            end
            ST_JTAG_RD: begin
                mond_load  = 1'b1;
                jtag_done  = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Held inactive during reset so an abandoned operation cannot corrupt the RAM.
    assign ram_wren    = wren_c & reset_n;
    assign av_readdata = reset_n ? readdata_c : '0;
    assign jtag_busy   = (pend_op != OP_NONE) | (state == ST_JTAG_RD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonDReg <= '0;
        end else if (mond_load) begin
            MonDReg <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_nios2os_ocimem_arbiter.sv
// Bench for nios2os_ocimem_arbiter: registered-RAM model, shadow memory and write/read scoreboards.
module tb_nios2os_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy, jtag_overrun;

    always #5 clk = ~clk;

    nios2os_ocimem_arbiter dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .MonDReg(MonDReg), .MonAReg(MonAReg),
        .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
    );

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] shadow [256];
    int          vectors = 0;
    int          miscompares = 0;
    wr_t         mon_e;
    logic [31:0] mon_m, mon_r;

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Scoreboard: every RAM write and every completed CPU read is checked against queued expectations.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (ram_wren === 1'b1) begin
                vectors++;
                if (wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL ram_write_unexpected: addr=%h be=%h data=%h, no write expected", ram_addr, ram_byteen, ram_wdata);
                end else begin
                    mon_e = wr_q.pop_front();
                    mon_m = bmask(mon_e.be);
                    if (ram_addr !== mon_e.addr || ram_byteen !== mon_e.be || (ram_wdata & mon_m) !== (mon_e.data & mon_m)) begin
                        miscompares++;
                        $display("FAIL ram_write: got addr=%h be=%h data=%h, want addr=%h be=%h data=%h",
                                 ram_addr, ram_byteen, ram_wdata, mon_e.addr, mon_e.be, mon_e.data);
                    end
                end
            end
            if (av_read === 1'b1 && av_write === 1'b0 && av_waitrequest === 1'b0) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cpu_read_unexpected: data=%h, no read expected", av_readdata);
                end else begin
                    mon_r = rd_q.pop_front();
                    if (av_readdata !== mon_r) begin
                        miscompares++;
                        $display("FAIL cpu_read: got %h want %h", av_readdata, mon_r);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [3:0] bev, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.be = bev; w.data = d;
        wr_q.push_back(w);
        for (int b = 0; b < 4; b++)
            if (bev[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        av_address = a; av_writedata = d; av_byteenable = bev; av_write = 1'b1;
        @(negedge clk);
        vectors++;
        if (av_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_write_wait: waitrequest=%b want 0", av_waitrequest);
        end
        tick();
        av_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        int n;
        rd_q.push_back(shadow[a]);
        av_address = a; av_read = 1'b1;
        n = 0;
        @(negedge clk);
        while (av_waitrequest === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL cpu_read_stall: stalled %0d cycles want 1", n);
        end
        tick();
        av_read = 1'b0;
    endtask

    task automatic jtag_strobe(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_jtag(output int busy);
        busy = 0;
        @(negedge clk);
        while (jtag_busy === 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        if (jtag_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL jtag_timeout: busy still %b", jtag_busy);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0; j[33:26] = a; j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0; j[34:3] = d;
        return j;
    endfunction

    task automatic test_reset;
        #1;
        vectors++;
        if ({ram_wren, av_readdata, MonAReg, MonDReg, jtag_overrun, jtag_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: wren=%b rdata=%h areg=%h dreg=%h ovr=%b busy=%b want all 0",
                     ram_wren, av_readdata, MonAReg, MonDReg, jtag_overrun, jtag_busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (av_waitrequest !== 1'b0 || jtag_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: waitreq=%b busy=%b want 0 0", av_waitrequest, jtag_busy);
        end
    endtask

    task automatic test_jtag_read;
        int n;
        cpu_write(8'h10, 4'hF, 32'hDEADBEEF);
        jtag_strobe(0, mk_a(8'h10, 1'b1));
        wait_jtag(n);
        vectors++;
        if (n != 2 || MonDReg !== 32'hDEADBEEF || MonAReg !== 8'h11) begin
            miscompares++;
            $display("FAIL jtag_read: busy=%0d dreg=%h areg=%h want 2 deadbeef 11", n, MonDReg, MonAReg);
        end
    endtask

    task automatic test_jtag_write_wrap;
        int n;
        wr_t w;
        jtag_strobe(0, mk_a(8'hFF, 1'b0));
        @(negedge clk);
        vectors++;
        if (MonAReg !== 8'hFF || jtag_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_load: areg=%h busy=%b want ff 0", MonAReg, jtag_busy);
        end
        tick();
        w.addr = 8'hFF; w.be = 4'hF; w.data = 32'h12345678;
        wr_q.push_back(w);
        shadow[8'hFF] = 32'h12345678;
        jtag_strobe(1, mk_b(32'h12345678));
        wait_jtag(n);
        vectors++;
        if (n != 1 || MonAReg !== 8'h00) begin
            miscompares++;
            $display("FAIL jtag_write_wrap: busy=%0d areg=%h want 1 00", n, MonAReg);
        end
        tick();
        cpu_read(8'hFF);
    endtask

    task automatic test_contention;
        int n;
        cpu_write(8'h20, 4'hF, 32'hCAFE0020);
        cpu_write(8'h00, 4'hF, 32'hA5A50000);
        jtag_strobe(2, '0);
        rd_q.push_back(shadow[8'h20]);
        av_address = 8'h20; av_read = 1'b1;
        n = 0;
        @(negedge clk);
        while (av_waitrequest === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL contention_stall: stalled %0d cycles want 3", n);
        end
        tick();
        av_read = 1'b0;
        vectors++;
        if (MonDReg !== 32'hA5A50000 || MonAReg !== 8'h01 || jtag_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_jtag: dreg=%h areg=%h busy=%b want a5a50000 01 0", MonDReg, MonAReg, jtag_busy);
        end
    endtask

    task automatic test_byte_write;
        cpu_write(8'h05, 4'hF, 32'h11223344);
        cpu_write(8'h05, 4'b0010, 32'h0000AB00);
        cpu_read(8'h05);
    endtask

    task automatic test_overrun;
        int n;
        cpu_write(8'h01, 4'hF, 32'h0BADF00D);
        jtag_strobe(2, '0);
        jtag_strobe(2, '0);
        wait_jtag(n);
        vectors++;
        if (n != 1 || MonDReg !== 32'h0BADF00D || MonAReg !== 8'h02 || jtag_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun: busy=%0d dreg=%h areg=%h ovr=%b want 1 0badf00d 02 1", n, MonDReg, MonAReg, jtag_overrun);
        end
        repeat (3) tick();
        vectors++;
        if (MonAReg !== 8'h02 || jtag_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_single: areg=%h busy=%b want 02 0", MonAReg, jtag_busy);
        end
        jtag_strobe(0, mk_a(8'h40, 1'b0));
        @(negedge clk);
        vectors++;
        if (jtag_overrun !== 1'b0 || MonAReg !== 8'h40) begin
            miscompares++;
            $display("FAIL overrun_clear: ovr=%b areg=%h want 0 40", jtag_overrun, MonAReg);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  bev;
        for (int i = 0; i < 6; i++) begin
            a   = 8'($urandom_range(64, 200));
            d   = $urandom;
            bev = 4'($urandom_range(1, 15));
            cpu_write(a, 4'hF, ~d);
            cpu_write(a, bev, d);
            cpu_read(a);
        end
    endtask

    task automatic test_reset_mid;
        av_address = 8'h30; av_read = 1'b1;
        tick();
        reset_n = 1'b0;
        av_read = 1'b0;
        #1;
        vectors++;
        if ({ram_wren, av_readdata, MonAReg, MonDReg, jtag_overrun, jtag_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: wren=%b rdata=%h areg=%h dreg=%h ovr=%b busy=%b want all 0",
                     ram_wren, av_readdata, MonAReg, MonDReg, jtag_overrun, jtag_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        cpu_read(8'h05);
        vectors++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: writes left=%0d reads left=%0d want 0 0", wr_q.size(), rd_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        test_reset();
        tick();
        test_jtag_read();
        test_jtag_write_wrap();
        test_contention();
        test_byte_write();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
